mouse_slave_sm: RTL and testbench
=================================

// Module: mouse_slave_sm
// PURPOSE
//  Device-side PS/2 mouse state machine: the responder to the host mouse-initialisation master.
//  Decodes host command bytes from the PS/2 byte receiver and answers through the PS/2 byte transmitter.
//  Accumulates movement and button input and streams standard 3-byte packets (status, dx, dy).
//  Used as a mouse emulator and as a loop-back partner for host-side bring-up.
// PARAMETERS
//  SELFTEST_DELAY  50000   cycles between FA and AA after reset cmd FF (1 ms @ 50 MHz)
//  PACKET_GAP      500000  min cycles between packet ends and next packet start (rate limit only)
// PORTS
//  CLK              in   1  system clock
//  RESET            in   1  synchronous, active-low reset
//  SEND_BYTE        out  1  one-cycle strobe to transmitter
//  BYTE_TO_SEND     out  8  byte for transmitter, held until next load
//  BYTE_SENT        in   1  transmitter done pulse
//  READ_ENABLE      out  1  receiver enable; high only in IDLE and packet states
//  BYTE_READ        in   8  received host byte
//  BYTE_ERROR_CODE  in   2  receiver error, 00 = good
//  BYTE_READY       in   1  receiver byte-valid pulse
//  MOVE_VALID       in   1  movement sample strobe
//  MOVE_DX/MOVE_DY  in   9  signed two's-complement movement sample
//  BUTTONS          in   3  {M,R,L}, level
//  STREAMING        out  1  data reporting enabled
//  PACKET_SENT      out  1  one-cycle pulse after dy byte sent
//  CURR_STATE       out  4  state encoding below
// BEHAVIOUR
//  Reset (RESET=0 at edge): all outputs 0, BYTE_TO_SEND=00, accumulators/overflow cleared, state 0.
//  States: 0 IDLE, 1 ACK_SEND, 2 ACK_WAIT, 3 SELFTEST, 4 BAT_SEND, 5 BAT_WAIT, 6 ID_SEND, 7 ID_WAIT,
//   8 ST_SEND, 9 ST_WAIT, A DX_SEND, B DX_WAIT, C DY_SEND, D DY_WAIT, E GAP; F -> IDLE.
//  *_SEND: one cycle; loads byte, registered SEND_BYTE=1 in first cycle of matching *_WAIT.
//  *_WAIT: hold until BYTE_SENT. Outputs all registered.
//  IDLE, BYTE_READY: err!=00 -> ACK byte FE, no state change; else ACK byte FA and decode:
//   FF reset -> clear STREAMING+acc; after ACK: SELFTEST (count SELFTEST_DELAY) -> AA -> 00 -> IDLE.
//   F4 -> STREAMING=1. F5, F6 -> STREAMING=0. F2 -> after ACK send 00. Other -> ACK only.
//   STREAMING updates on ACK_SEND entry.
//  IDLE, no BYTE_READY, STREAMING=1, (acc!=0 or BUTTONS!=last sent) -> capture packet, clear acc -> ST_SEND.
//   BYTE_READY has priority over packet start in the same cycle.
//  Status = {Y_OVF,X_OVF,Y_SIGN,X_SIGN,1,M,R,L}; dx/dy = acc[7:0]; sign = acc[8].
//  Accumulate (only while STREAMING, in any state): acc += MOVE_*; saturate to [-256,+255], set sticky OVF.
//   MOVE_VALID in capture cycle lands in freshly cleared acc (not lost).
//  BYTE_READY during states 8-D: latch cmd; finish current byte's BYTE_SENT, drop rest of packet,
//   no PACKET_SENT, -> ACK_SEND with latched cmd. Captured movement of aborted packet discarded.
//  BYTE_READY in states 1-7 ignored (READ_ENABLE=0).
//  DY_WAIT + BYTE_SENT -> PACKET_SENT pulse, -> IDLE (or GAP, see below).
// CONFIGURATION
//  MOUSE_SLAVE_RATE_LIMIT_EN defined: after DY_WAIT enter GAP, count PACKET_GAP cycles -> IDLE;
//   READ_ENABLE=1 in GAP; BYTE_READY in GAP -> ACK_SEND immediately, counter cleared.
//  Undefined: GAP never entered, packets back-to-back; PACKET_GAP unused.
// TESTING
//  Host FF, err 00 -> bytes FA, AA (>= SELFTEST_DELAY after FA sent), 00; STREAMING=0; CURR_STATE back to 0.
//  F4, then MOVE dx=+5 dy=-3 BUTTONS=001 -> FA, then packet 29,05,FD; PACKET_SENT one pulse.
//  Streaming, two moves dx=+200 during packet TX -> next packet 48,FF,00 (X_OVF, saturated).
//  BYTE_READY with err=01 -> FE sent, STREAMING unchanged, no packet lost from acc.
//  F5 arrives in DX_WAIT -> dx byte completes, dy not sent, FA sent, STREAMING=0, no PACKET_SENT.
//  RESET=0 during BAT_WAIT -> next cycle all outputs 0, CURR_STATE=0; rate-limit build: gap >= PACKET_GAP.

Source files
------------

// File: rtl/mouse_slave_sm_if.sv
// Byte-level PS/2 transceiver handshakes and movement/button inputs of the emulated mouse.
// The slave modport is the mouse state machine; the master modport is the host/transceiver side.
interface mouse_slave_sm_if;
  logic              SEND_BYTE;
  logic [7:0]        BYTE_TO_SEND;
  logic              BYTE_SENT;
  logic              READ_ENABLE;
  logic [7:0]        BYTE_READ;
  logic [1:0]        BYTE_ERROR_CODE;
  logic              BYTE_READY;
  logic              MOVE_VALID;
  logic signed [8:0] MOVE_DX;
  logic signed [8:0] MOVE_DY;
  logic [2:0]        BUTTONS;
  logic              STREAMING;
  logic              PACKET_SENT;
  logic [3:0]        CURR_STATE;

  modport slave (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, STREAMING, PACKET_SENT, CURR_STATE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    input  MOVE_VALID, MOVE_DX, MOVE_DY, BUTTONS
  );

  modport master (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, STREAMING, PACKET_SENT, CURR_STATE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    output MOVE_VALID, MOVE_DX, MOVE_DY, BUTTONS
  );
endinterface

// File: rtl/mouse_slave_sm.sv
// Device-side PS/2 mouse: answers host commands and streams 3-byte movement packets.
// Optional inter-packet rate limit enabled by defining MOUSE_SLAVE_RATE_LIMIT_EN.
module mouse_slave_sm #(
  parameter int SELFTEST_DELAY = 50000,
  parameter int PACKET_GAP     = 500000
) (
  input logic           CLK,
  input logic           RESET,
  mouse_slave_sm_if.slave bus
);
  localparam logic [3:0] S_IDLE     = 4'h0, S_ACK_SEND = 4'h1, S_ACK_WAIT = 4'h2,
                         S_SELFTEST = 4'h3, S_BAT_SEND = 4'h4, S_BAT_WAIT = 4'h5,
                         S_ID_SEND  = 4'h6, S_ID_WAIT  = 4'h7, S_ST_SEND  = 4'h8,
                         S_ST_WAIT  = 4'h9, S_DX_SEND  = 4'hA, S_DX_WAIT  = 4'hB,
                         S_DY_SEND  = 4'hC, S_DY_WAIT  = 4'hD;
`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
  localparam logic [3:0] S_GAP = 4'hE;
`endif
  localparam int CNT_MAX = (SELFTEST_DELAY > PACKET_GAP) ? SELFTEST_DELAY : PACKET_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SELFTEST_LAST = CNT_W'(SELFTEST_DELAY - 1);
`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(PACKET_GAP - 1);
`endif
  localparam logic signed [9:0] SAT_HI = 10'sd255;
  localparam logic signed [9:0] SAT_LO = -10'sd256;

  logic [3:0]        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              send_byte_r, read_en_r, streaming_r, pkt_sent_r;
  logic [7:0]        byte_r, byte_n;
  logic signed [8:0] acc_x, acc_y, base_x, base_y;
  logic              ovf_x, ovf_y;
  logic [9:0]        sum_x, sum_y;
  logic [2:0]        last_btn, pkt_btn;
  logic [7:0]        cmd_q, ack_cmd, pkt_st, pkt_dx, pkt_dy;
  logic              cmd_ok, ack_ok, abort_q, abort;
  logic              rd_new, in_pkt, pkt_pending, enter_ack, capture, pkt_done, load, clr_all;

  // {overflow, saturated 9-bit sum} of two signed movement values
  function automatic logic [9:0] sat_add(input logic signed [8:0] a, input logic signed [8:0] b);
    logic signed [9:0] s;
    s = $signed({a[8], a}) + $signed({b[8], b});
    if (s > SAT_HI)      return {1'b1, 9'h0FF};
    else if (s < SAT_LO) return {1'b1, 9'h100};
    else                 return {1'b0, s[8:0]};
  endfunction

  function automatic logic rd_state(input logic [3:0] s);
    logic r;
    r = (s == S_IDLE) || (s >= S_ST_SEND && s <= S_DY_WAIT);
`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
    r = r || (s == S_GAP);
`endif
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    enter_ack   = 1'b0;
    capture     = 1'b0;
    pkt_done    = 1'b0;
    load        = 1'b0;
    byte_n      = 8'h00;
    in_pkt      = (state >= S_ST_SEND) && (state <= S_DY_WAIT);
    rd_new      = bus.BYTE_READY && rd_state(state);
    abort       = abort_q || (rd_new && in_pkt);
    ack_cmd     = rd_new ? bus.BYTE_READ : cmd_q;
    ack_ok      = rd_new ? (bus.BYTE_ERROR_CODE == 2'b00) : cmd_ok;
    pkt_pending = streaming_r && (acc_x != 9'sd0 || acc_y != 9'sd0 || bus.BUTTONS != last_btn);
    case (state)
      S_IDLE:     if (rd_new) enter_ack = 1'b1;
                  else if (pkt_pending) begin
                    capture = 1'b1;
                    state_n = S_ST_SEND;
                  end
      S_ACK_SEND: begin
                    load    = 1'b1;
                    byte_n  = cmd_ok ? 8'hFA : 8'hFE;
                    state_n = S_ACK_WAIT;
                  end
      S_ACK_WAIT: if (bus.BYTE_SENT) begin
                    if (cmd_ok && cmd_q == 8'hFF)      state_n = S_SELFTEST;
                    else if (cmd_ok && cmd_q == 8'hF2) state_n = S_ID_SEND;
                    else                               state_n = S_IDLE;
                  end
      S_SELFTEST: if (cnt == SELFTEST_LAST) state_n = S_BAT_SEND;
      S_BAT_SEND: begin load = 1'b1; byte_n = 8'hAA; state_n = S_BAT_WAIT; end
      S_BAT_WAIT: if (bus.BYTE_SENT) state_n = S_ID_SEND;
      S_ID_SEND:  begin load = 1'b1; byte_n = 8'h00; state_n = S_ID_WAIT; end
      S_ID_WAIT:  if (bus.BYTE_SENT) state_n = S_IDLE;
      S_ST_SEND, S_DX_SEND, S_DY_SEND:
                  if (abort) enter_ack = 1'b1;
                  else begin
                    load    = 1'b1;
                    byte_n  = (state == S_ST_SEND) ? pkt_st : (state == S_DX_SEND) ? pkt_dx : pkt_dy;
                    state_n = state + 4'd1;
                  end
      S_ST_WAIT, S_DX_WAIT:
                  if (bus.BYTE_SENT) begin
                    if (abort) enter_ack = 1'b1;
                    else       state_n = state + 4'd1;
                  end
      S_DY_WAIT:  if (bus.BYTE_SENT) begin
                    if (abort) enter_ack = 1'b1;
                    else begin
                      pkt_done = 1'b1;
`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
                      state_n  = S_GAP;
`else
                      state_n  = S_IDLE;
`endif
                    end
                  end
`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
      S_GAP:      if (rd_new) enter_ack = 1'b1;
                  else if (cnt == GAP_LAST) state_n = S_IDLE;
`endif
      default:    state_n = S_IDLE;
    endcase
    if (enter_ack) state_n = S_ACK_SEND;
    clr_all = enter_ack && ack_ok && (ack_cmd == 8'hFF);
    // A sample arriving in the capture cycle lands in the freshly cleared accumulator
    base_x  = capture ? 9'sd0 : acc_x;
    base_y  = capture ? 9'sd0 : acc_y;
    sum_x   = sat_add(base_x, bus.MOVE_DX);
    sum_y   = sat_add(base_y, bus.MOVE_DY);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      send_byte_r <= 1'b0;
      byte_r      <= 8'h00;
      read_en_r   <= 1'b0;
      streaming_r <= 1'b0;
      pkt_sent_r  <= 1'b0;
      acc_x       <= 9'sd0;
      acc_y       <= 9'sd0;
      ovf_x       <= 1'b0;
      ovf_y       <= 1'b0;
      last_btn    <= 3'b000;
      cmd_q       <= 8'h00;
      cmd_ok      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= (state_n != state) ? '0 : cnt + 1'b1;
      send_byte_r <= load;
      if (load) byte_r <= byte_n;
      read_en_r   <= rd_state(state_n);
      pkt_sent_r  <= pkt_done;
      if (pkt_done) last_btn <= pkt_btn;
      if (rd_new && in_pkt) begin
        cmd_q   <= bus.BYTE_READ;
        cmd_ok  <= (bus.BYTE_ERROR_CODE == 2'b00);
        abort_q <= 1'b1;
      end
      if (enter_ack) begin
        cmd_q   <= ack_cmd;
        cmd_ok  <= ack_ok;
        abort_q <= 1'b0;
        if (ack_ok) begin
          case (ack_cmd)
            8'hF4:               streaming_r <= 1'b1;
            8'hF5, 8'hF6, 8'hFF: streaming_r <= 1'b0;
            default: ;
          endcase
        end
      end
      if (clr_all) begin
        acc_x <= 9'sd0;
        acc_y <= 9'sd0;
        ovf_x <= 1'b0;
        ovf_y <= 1'b0;
      end else if (streaming_r && bus.MOVE_VALID) begin
        acc_x <= sum_x[8:0];
        acc_y <= sum_y[8:0];
        ovf_x <= (ovf_x && !capture) || sum_x[9];
        ovf_y <= (ovf_y && !capture) || sum_y[9];
      end else if (capture) begin
        acc_x <= 9'sd0;
        acc_y <= 9'sd0;
        ovf_x <= 1'b0;
        ovf_y <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      pkt_st  <= {ovf_y, ovf_x, acc_y[8], acc_x[8], 1'b1, bus.BUTTONS};
      pkt_dx  <= acc_x[7:0];
      pkt_dy  <= acc_y[7:0];
      pkt_btn <= bus.BUTTONS;
    end
  end

  assign bus.SEND_BYTE    = send_byte_r;
  assign bus.BYTE_TO_SEND = byte_r;
  assign bus.READ_ENABLE  = read_en_r;
  assign bus.STREAMING    = streaming_r;
  assign bus.PACKET_SENT  = pkt_sent_r;
  assign bus.CURR_STATE   = state;
endmodule

// File: tb/tb_mouse_slave_sm.sv
// Directed bench for mouse_slave_sm: transmitter model, host command stimulus, byte-stream checks.
module tb_mouse_slave_sm;
  localparam int SELFTEST_DELAY = 20;
  localparam int PACKET_GAP     = 30;
  localparam int TX_LAT         = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  mouse_slave_sm_if bus();
  mouse_slave_sm #(.SELFTEST_DELAY(SELFTEST_DELAY), .PACKET_GAP(PACKET_GAP)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pkt_cnt  = 0;
  int last_pkt_cyc = 0;
  logic [7:0] tx_q[$];
  int sent_at[$];
  int done_at[$];

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (bus.PACKET_SENT) begin
    pkt_cnt      <= pkt_cnt + 1;
    last_pkt_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: accept each SEND_BYTE strobe, report done TX_LAT cycles later
  initial begin
    bus.BYTE_SENT = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.SEND_BYTE === 1'b1) begin
        tx_q.push_back(bus.BYTE_TO_SEND);
        sent_at.push_back(cyc);
        repeat (TX_LAT) @(negedge CLK);
        bus.BYTE_SENT = 1'b1;
        done_at.push_back(cyc);
        @(negedge CLK);
        bus.BYTE_SENT = 1'b0;
      end
    end
  end

  task automatic host_send(input logic [7:0] c, input logic [1:0] e);
    bus.BYTE_READ = c;
    bus.BYTE_ERROR_CODE = e;
    bus.BYTE_READY = 1'b1;
    @(negedge CLK);
    bus.BYTE_READY = 1'b0;
    bus.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic move(input logic signed [8:0] dx, input logic signed [8:0] dy);
    bus.MOVE_VALID = 1'b1;
    bus.MOVE_DX = dx;
    bus.MOVE_DY = dy;
    @(negedge CLK);
    bus.MOVE_VALID = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int k = 0;
    while (bus.CURR_STATE !== s && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check($sformatf("state_%0h", s), {28'd0, bus.CURR_STATE}, {28'd0, s});
  endtask

  // Expected bytes packed first-to-last into exp, n bytes
  task automatic expect_bytes(input string tag, input int n, input logic [47:0] exp);
    int k = 0;
    logic [7:0] got;
    while (tx_q.size() < n && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check({tag, "_count"}, tx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      check($sformatf("%s[%0d]", tag, i), {24'd0, got}, {24'd0, exp[8*(n-1-i) +: 8]});
    end
    for (int i = 0; i < n; i++) if (tx_q.size() > 0) void'(tx_q.pop_front());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_send"},   {31'd0, bus.SEND_BYTE},    0);
    check({tag, "_byte"},   {24'd0, bus.BYTE_TO_SEND}, 0);
    check({tag, "_rden"},   {31'd0, bus.READ_ENABLE},  0);
    check({tag, "_strm"},   {31'd0, bus.STREAMING},    0);
    check({tag, "_psent"},  {31'd0, bus.PACKET_SENT},  0);
    check({tag, "_state"},  {28'd0, bus.CURR_STATE},   0);
  endtask

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int diff;
    bus.BYTE_READ = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00;
    bus.BYTE_READY = 1'b0;
    bus.MOVE_VALID = 1'b0;
    bus.MOVE_DX = 9'sd0;
    bus.MOVE_DY = 9'sd0;
    bus.BUTTONS = 3'b000;

    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("rden_idle", {31'd0, bus.READ_ENABLE}, 1);

    // Reset command: FA, self-test delay, AA, 00
    base = sent_at.size();
    host_send(8'hFF, 2'b00);
    expect_bytes("ff_seq", 3, 48'hFAAA00);
    diff = (sent_at.size() > base + 1 && done_at.size() > base) ? sent_at[base+1] - done_at[base] : 0;
    check("bat_delay_ok", {31'd0, diff >= SELFTEST_DELAY}, 1);
    wait_state(4'h0, 50);
    check("ff_strm", {31'd0, bus.STREAMING}, 0);

    // Enable reporting, then one move with left button
    host_send(8'hF4, 2'b00);
    expect_bytes("f4_ack", 1, 48'hFA);
    wait_state(4'h0, 50);
    check("f4_strm", {31'd0, bus.STREAMING}, 1);
    move(9'sd5, -9'sd3);
    bus.BUTTONS = 3'b001;
    expect_bytes("pkt1", 3, 48'h2905FD);
    wait_state(4'h0, 50);
    repeat (2) @(negedge CLK);
    check("pkt1_sent", pkt_cnt, 1);

    // Button release starts a packet; two large moves during it saturate the next one
    bus.BUTTONS = 3'b000;
    wait_state(4'h9, 20);
    move(9'sd200, 9'sd0);
    move(9'sd200, 9'sd0);
    expect_bytes("ovf", 6, 48'h08000048FF00);
    wait_state(4'h0, 50);
    repeat (2) @(negedge CLK);
    check("ovf_sent", pkt_cnt, 3);

    // Receive error with simultaneous move: FE, streaming kept, move still reported
    bus.BYTE_READ = 8'hF5;
    bus.BYTE_ERROR_CODE = 2'b01;
    bus.BYTE_READY = 1'b1;
    move(9'sd1, 9'sd0);
    bus.BYTE_READY = 1'b0;
    bus.BYTE_ERROR_CODE = 2'b00;
    expect_bytes("err", 4, 48'hFE080100);
    check("err_strm", {31'd0, bus.STREAMING}, 1);
    wait_state(4'h0, 50);
    repeat (2) @(negedge CLK);
    check("err_sent", pkt_cnt, 4);

    // Disable command during dx byte aborts the packet
    move(9'sd3, 9'sd0);
    wait_state(4'hB, 40);
    host_send(8'hF5, 2'b00);
    expect_bytes("abort", 3, 48'h0803FA);
    wait_state(4'h0, 50);
    repeat (20) @(negedge CLK);
    check("abort_no_dy", tx_q.size(), 0);
    check("abort_strm", {31'd0, bus.STREAMING}, 0);
    check("abort_nopkt", pkt_cnt, 4);

    // Reset asserted in BAT_WAIT clears every output on the next cycle
    host_send(8'hFF, 2'b00);
    wait_state(4'h5, 200);
    check("bat_send_strobe", {31'd0, bus.SEND_BYTE}, 1);
    RESET = 1'b0;
    @(negedge CLK);
    check_outputs_zero("midreset");
    RESET = 1'b1;
    repeat (TX_LAT + 4) @(negedge CLK);
    tx_q.delete();

`ifdef MOUSE_SLAVE_RATE_LIMIT_EN
    host_send(8'hF4, 2'b00);
    expect_bytes("rl_ack", 1, 48'hFA);
    wait_state(4'h0, 50);
    move(9'sd1, 9'sd0);
    expect_bytes("rl_pkt1", 3, 48'h080100);
    move(9'sd1, 9'sd0);
    base = sent_at.size();
    expect_bytes("rl_pkt2", 3, 48'h080100);
    diff = (sent_at.size() > base) ? sent_at[base] - last_pkt_cyc : 0;
    check("rl_gap_ok", {31'd0, diff >= PACKET_GAP}, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
